// File: rtl/ct_f_spsram_lane_init_if.sv
// ct_f_spsram_lane_init_if: access and init-control bundle for the lane-writable single-port SRAM
interface ct_f_spsram_lane_init_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  INIT_REQ;
    logic                  INIT_BUSY;
    logic                  INIT_DONE;
    modport master (output A, CEN, GWEN, WEN, D, INIT_REQ, input Q, INIT_BUSY, INIT_DONE);
    modport slave  (input A, CEN, GWEN, WEN, D, INIT_REQ, output Q, INIT_BUSY, INIT_DONE);
endinterface

// File: rtl/ct_f_spsram_lane_init.sv
// ct_f_spsram_lane_init: parametrised single-port SRAM with lane writes, optional output register and init sweeper
module ct_f_spsram_lane_init #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    LANE_WIDTH = 8,
    parameter int                    OUT_REG    = 0,
    parameter int                    AUTO_INIT  = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input logic                    CLK,
    input logic                    cpurst_b,
    ct_f_spsram_lane_init_if.slave bus
);
    localparam int NLANE = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    typedef enum logic {IDLE, INIT} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, addr, addr_holding;
    logic [NLANE-1:0]      lane_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word, q_raw;
    logic                  done;
    logic                  wen_unused;
    assign wen_unused = ^bus.WEN;
    assign addr = bus.CEN ? addr_holding : bus.A;
    // only the top mask bit of each lane gates that lane
    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        assign lane_we[k] = state == IDLE && !bus.CEN && !bus.GWEN && !bus.WEN[k*LANE_WIDTH+LANE_WIDTH-1];
    end
    always_comb begin
        rd_word = mem[addr];
        for (int k = 0; k < NLANE; k++)
            if (lane_we[k]) rd_word[k*LANE_WIDTH +: LANE_WIDTH] = bus.D[k*LANE_WIDTH +: LANE_WIDTH];
    end
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (bus.INIT_REQ ? INIT : IDLE) : (&cnt ? IDLE : INIT);
    end
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state        <= AUTO_INIT != 0 ? INIT : IDLE;
            cnt          <= '0;
            addr_holding <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= state == INIT ? cnt + 1'b1 : '0;
            addr_holding <= state == IDLE && !bus.CEN ? bus.A : addr_holding;
            done         <= state == INIT && &cnt;
        end
    end
    // array and read stage carry no reset so they map onto RAM primitives
    always_ff @(posedge CLK) begin
        if (state == INIT)
            mem[cnt] <= INIT_VAL;
        else
            for (int k = 0; k < NLANE; k++)
                if (lane_we[k]) mem[addr][k*LANE_WIDTH +: LANE_WIDTH] <= bus.D[k*LANE_WIDTH +: LANE_WIDTH];
        q_raw <= rd_word;
    end
    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] q_pipe;
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) q_pipe <= '0;
            else           q_pipe <= q_raw;
        end
        assign bus.Q = q_pipe;
    end else begin : g_noreg
        assign bus.Q = q_raw;
    end
    assign bus.INIT_BUSY = state == INIT;
    assign bus.INIT_DONE = done;
endmodule

// File: tb/tb_ct_f_spsram_lane_init.sv
// tb_ct_f_spsram_lane_init: directed checks of lane writes, hold, latency and init sweeps
module tb_ct_f_spsram_lane_init;
    localparam int          DW = 32;
    localparam int          AW = 4;
    localparam logic [31:0] IV = 32'h5A5A_C3C3;
    logic CLK = 1'b0;
    logic cpurst_b = 1'b0;
    int   tests = 0;
    int   fails = 0;
    always #5 CLK = ~CLK;
    ct_f_spsram_lane_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
    ct_f_spsram_lane_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    ct_f_spsram_lane_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(8), .OUT_REG(0), .AUTO_INIT(1), .INIT_VAL(IV))
        dut0 (.CLK(CLK), .cpurst_b(cpurst_b), .bus(b0));
    ct_f_spsram_lane_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(8), .OUT_REG(1), .AUTO_INIT(1), .INIT_VAL(IV))
        dut1 (.CLK(CLK), .cpurst_b(cpurst_b), .bus(b1));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic idle_bus;
        b0.A = '0; b0.CEN = 1'b1; b0.GWEN = 1'b1; b0.WEN = '1; b0.D = '0; b0.INIT_REQ = 1'b0;
        b1.A = '0; b1.CEN = 1'b1; b1.GWEN = 1'b1; b1.WEN = '1; b1.D = '0; b1.INIT_REQ = 1'b0;
    endtask
    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] w);
        b0.A = a; b0.D = d; b0.WEN = w; b0.CEN = 1'b0; b0.GWEN = 1'b0;
        tick();
        b0.CEN = 1'b1; b0.GWEN = 1'b1; b0.WEN = '1;
    endtask
    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        b1.A = a; b1.D = d; b1.WEN = '0; b1.CEN = 1'b0; b1.GWEN = 1'b0;
        tick();
        b1.CEN = 1'b1; b1.GWEN = 1'b1; b1.WEN = '1;
    endtask
    task automatic rd0(input logic [AW-1:0] a, output logic [DW-1:0] q);
        b0.A = a; b0.CEN = 1'b0; b0.GWEN = 1'b1;
        tick();
        q = b0.Q;
        b0.CEN = 1'b1;
    endtask
    task automatic wait_idle0(output int n);
        n = 0;
        while (b0.INIT_BUSY && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        logic [DW-1:0] q;
        int n;
        idle_bus();
        cpurst_b = 1'b0;
        #12;
        tests++; if (b0.INIT_BUSY !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", b0.INIT_BUSY); end
        tests++; if (b0.INIT_DONE !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", b0.INIT_DONE); end
        tests++; if (b1.Q !== 32'h0) begin fails++; $display("FAIL reset_qreg: got %h want 0", b1.Q); end
        @(posedge CLK);
        #1;
        cpurst_b = 1'b1;
        wait_idle0(n);
        tests++; if (n !== 16) begin fails++; $display("FAIL auto_sweep_len: got %0d want 16", n); end
        tests++; if (b0.INIT_DONE !== 1'b1) begin fails++; $display("FAIL auto_done_pulse: got %b want 1", b0.INIT_DONE); end
        tests++; if (b1.INIT_BUSY !== 1'b0) begin fails++; $display("FAIL auto_busy1: got %b want 0", b1.INIT_BUSY); end
        tick();
        tests++; if (b0.INIT_DONE !== 1'b0) begin fails++; $display("FAIL auto_done_clear: got %b want 0", b0.INIT_DONE); end
        for (int i = 0; i < 16; i++) begin
            rd0(AW'(i), q);
            tests++; if (q !== IV) begin fails++; $display("FAIL init_word[%0d]: got %h want %h", i, q, IV); end
        end
    endtask

    task automatic test_lane_write;
        logic [DW-1:0] q;
        wr0(4'h5, 32'h0, 32'h0);
        wr0(4'h5, 32'hA5A5_1234, 32'hFF00_FF00);
        tests++; if (b0.Q !== 32'h00A5_0034) begin fails++; $display("FAIL lane_write_rdw: got %h want 00a50034", b0.Q); end
        rd0(4'h5, q);
        tests++; if (q !== 32'h00A5_0034) begin fails++; $display("FAIL lane_write: got %h want 00a50034", q); end
    endtask

    task automatic test_lane_mask;
        logic [DW-1:0] q;
        wr0(4'h9, 32'h0, 32'h0);
        wr0(4'h9, 32'hFFFF_FFFF, 32'h7F7F_7F7F);
        rd0(4'h9, q);
        tests++; if (q !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mask_top_bits: got %h want ffffffff", q); end
        wr0(4'h9, 32'h0, 32'h8080_8080);
        rd0(4'h9, q);
        tests++; if (q !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mask_low_ignored: got %h want ffffffff", q); end
        b0.A = 4'h9; b0.D = 32'h0; b0.WEN = '0; b0.CEN = 1'b0; b0.GWEN = 1'b1;
        tick();
        b0.CEN = 1'b1; b0.WEN = '1;
        rd0(4'h9, q);
        tests++; if (q !== 32'hFFFF_FFFF) begin fails++; $display("FAIL gwen_read: got %h want ffffffff", q); end
        wr0(4'h9, 32'h1234_5678, 32'hFFFF_0000);
        tests++; if (b0.Q !== 32'hFFFF_5678) begin fails++; $display("FAIL write_first: got %h want ffff5678", b0.Q); end
    endtask

    task automatic test_hold;
        logic [DW-1:0] q;
        logic [AW-1:0] alist [4] = '{4'h5, 4'h9, 4'h0, 4'h5};
        wr0(4'h3, 32'hDEAD_BEEF, 32'h0);
        rd0(4'h3, q);
        tests++; if (q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hold_read: got %h want deadbeef", q); end
        for (int i = 0; i < 4; i++) begin
            b0.A = alist[i]; b0.D = 32'hCAFE_0000 + i;
            tick();
            tests++; if (b0.Q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hold[%0d]: got %h want deadbeef", i, b0.Q); end
        end
    endtask

    task automatic test_out_reg;
        wr1(4'h1, 32'h1111_2222);
        wr1(4'h2, 32'h3333_4444);
        b1.A = 4'h1; b1.CEN = 1'b0;
        tick();
        tests++; if (b1.Q !== 32'h3333_4444) begin fails++; $display("FAIL oreg_edge1: got %h want 33334444", b1.Q); end
        b1.A = 4'h2;
        tick();
        tests++; if (b1.Q !== 32'h1111_2222) begin fails++; $display("FAIL oreg_rd1: got %h want 11112222", b1.Q); end
        b1.CEN = 1'b1;
        tick();
        tests++; if (b1.Q !== 32'h3333_4444) begin fails++; $display("FAIL oreg_rd2: got %h want 33334444", b1.Q); end
    endtask

    task automatic test_init_req;
        logic [DW-1:0] q;
        int n;
        b0.A = 4'h7; b0.D = 32'h1111_1111; b0.WEN = '0; b0.CEN = 1'b0; b0.GWEN = 1'b0; b0.INIT_REQ = 1'b1;
        tick();
        idle_bus();
        tests++; if (b0.INIT_BUSY !== 1'b1) begin fails++; $display("FAIL req_busy: got %b want 1", b0.INIT_BUSY); end
        tests++; if (b0.Q !== 32'h1111_1111) begin fails++; $display("FAIL req_write: got %h want 11111111", b0.Q); end
        repeat (4) tick();
        b0.INIT_REQ = 1'b1; b0.A = 4'h0; b0.D = 32'hFFFF_0000; b0.WEN = '0; b0.CEN = 1'b0; b0.GWEN = 1'b0;
        tick();
        idle_bus();
        wait_idle0(n);
        tests++; if (n !== 11) begin fails++; $display("FAIL req_sweep_rest: got %0d want 11", n); end
        tests++; if (b0.INIT_DONE !== 1'b1) begin fails++; $display("FAIL req_done: got %b want 1", b0.INIT_DONE); end
        rd0(4'h7, q);
        tests++; if (q !== IV) begin fails++; $display("FAIL req_word7: got %h want %h", q, IV); end
        rd0(4'h0, q);
        tests++; if (q !== IV) begin fails++; $display("FAIL busy_write_ignored: got %h want %h", q, IV); end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        b0.INIT_REQ = 1'b1;
        tick();
        b0.INIT_REQ = 1'b0;
        repeat (9) tick();
        cpurst_b = 1'b0;
        #2;
        tests++; if (b0.INIT_BUSY !== 1'b1) begin fails++; $display("FAIL midrst_busy: got %b want 1", b0.INIT_BUSY); end
        tests++; if (b0.INIT_DONE !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b want 0", b0.INIT_DONE); end
        @(posedge CLK);
        #1;
        cpurst_b = 1'b1;
        wait_idle0(n);
        tests++; if (n !== 16) begin fails++; $display("FAIL midrst_sweep_len: got %0d want 16", n); end
        tests++; if (b0.INIT_DONE !== 1'b1) begin fails++; $display("FAIL midrst_done_pulse: got %b want 1", b0.INIT_DONE); end
    endtask

    initial begin
        test_reset();
        test_lane_write();
        test_lane_mask();
        test_hold();
        test_out_reg();
        test_init_req();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
